// File: rtl/terminal_writer.sv
// Text terminal front end: turns an ASCII stream into VRAM cell writes with cursor tracking,
// line wrap and circular-buffer scrolling. Define TERMINAL_WRITER_TAB_EN to honour TAB (0x09).
module terminal_writer #(
  parameter int unsigned ROW_BITS     = 5,
  parameter int unsigned COL_BITS     = 7,
  parameter int unsigned VISIBLE_ROWS = 24,
  parameter int unsigned VISIBLE_COLS = 80
) (
  input  logic                clk,
  input  logic                reset,
  output logic                character_ready,
  input  logic                character_valid,
  input  logic [7:0]          character_byte,
  input  logic                write_ready,
  output logic                write_valid,
  output logic [ROW_BITS-1:0] write_row,
  output logic [COL_BITS-1:0] write_col,
  output logic [7:0]          write_byte,
  output logic [ROW_BITS-1:0] top_row
);

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StClear = 2'd3;

  localparam logic [ROW_BITS-1:0] LastLine = ROW_BITS'(VISIBLE_ROWS - 1);
  localparam logic [COL_BITS-1:0] LastCol  = COL_BITS'(VISIBLE_COLS - 1);
  localparam logic [7:0]          Space    = 8'h20;

  logic [1:0]          state_q, state_d;
  logic [ROW_BITS-1:0] top_q, top_d;
  logic [ROW_BITS-1:0] line_q, line_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                wv_q, wv_d;
  logic [ROW_BITS-1:0] wrow_q, wrow_d;
  logic [COL_BITS-1:0] wcol_q, wcol_d;
  logic [7:0]          wbyte_q, wbyte_d;
  logic                do_nl;
  logic [ROW_BITS-1:0] cur_row;

  // Physical row wraps naturally in ROW_BITS-wide arithmetic.
  assign cur_row = top_q + line_q;

`ifdef TERMINAL_WRITER_TAB_EN
  logic [COL_BITS:0]   tab_sum;
  logic [COL_BITS-1:0] tab_col;
  assign tab_sum = {1'b0, col_q | COL_BITS'(7)} + (COL_BITS + 1)'(1);
  assign tab_col = (tab_sum >= (COL_BITS + 1)'(VISIBLE_COLS)) ? LastCol : tab_sum[COL_BITS-1:0];
`endif

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    line_d  = line_q;
    col_d   = col_q;
    wv_d    = wv_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    wbyte_d = wbyte_q;
    do_nl   = 1'b0;
    unique case (state_q)
      StInit: begin
        // line_q/col_q double as the fill counters; both end at zero.
        if (!wv_q) begin
          wv_d    = 1'b1;
          wrow_d  = line_q;
          wcol_d  = col_q;
          wbyte_d = Space;
        end else if (write_ready) begin
          if (col_q == LastCol) begin
            col_d  = '0;
            wcol_d = '0;
            if (line_q == LastLine) begin
              line_d  = '0;
              wv_d    = 1'b0;
              state_d = StIdle;
            end else begin
              line_d = line_q + ROW_BITS'(1);
              wrow_d = line_q + ROW_BITS'(1);
            end
          end else begin
            col_d  = col_q + COL_BITS'(1);
            wcol_d = col_q + COL_BITS'(1);
          end
        end
      end
      StIdle: begin
        wv_d = 1'b0;
        if (character_valid) begin
          if (character_byte >= 8'h20 && character_byte <= 8'h7e) begin
            state_d = StWrite;
            wv_d    = 1'b1;
            wrow_d  = cur_row;
            wcol_d  = col_q;
            wbyte_d = character_byte;
          end else begin
            case (character_byte)
              8'h0d: col_d = '0;
              8'h0a: do_nl = 1'b1;
              8'h08: if (col_q != '0) col_d = col_q - COL_BITS'(1);
`ifdef TERMINAL_WRITER_TAB_EN
              8'h09: col_d = tab_col;
`endif
              default: ;
            endcase
          end
        end
      end
      StWrite: begin
        if (write_ready) begin
          wv_d = 1'b0;
          if (col_q < LastCol) begin
            col_d   = col_q + COL_BITS'(1);
            state_d = StIdle;
          end else begin
            col_d = '0;
            do_nl = 1'b1;
          end
        end
      end
      StClear: begin
        if (write_ready) begin
          if (col_q == LastCol) begin
            col_d   = '0;
            wv_d    = 1'b0;
            state_d = StIdle;
          end else begin
            col_d  = col_q + COL_BITS'(1);
            wcol_d = col_q + COL_BITS'(1);
          end
        end
      end
      default: state_d = StInit;
    endcase

    // Scroll: new bottom row is (top+1) + (VISIBLE_ROWS-1) = top + VISIBLE_ROWS.
    if (do_nl) begin
      if (line_q < LastLine) begin
        line_d  = line_q + ROW_BITS'(1);
        state_d = StIdle;
      end else begin
        top_d   = top_q + ROW_BITS'(1);
        state_d = StClear;
        col_d   = '0;
        wv_d    = 1'b1;
        wrow_d  = top_q + ROW_BITS'(VISIBLE_ROWS);
        wcol_d  = '0;
        wbyte_d = Space;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      top_q   <= '0;
      line_q  <= '0;
      col_q   <= '0;
      wv_q    <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wbyte_q <= Space;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      line_q  <= line_d;
      col_q   <= col_d;
      wv_q    <= wv_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      wbyte_q <= wbyte_d;
    end
  end

  assign character_ready = (state_q == StIdle) && !reset;
  assign write_valid     = wv_q && !reset;
  assign write_row       = wrow_q;
  assign write_col       = wcol_q;
  assign write_byte      = wbyte_q;
  assign top_row         = top_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Scoreboard bench for terminal_writer: expected VRAM writes are queued at stimulus time
// and a negedge monitor pops and compares each write handshake.
module tb_terminal_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       character_ready;
  logic       character_valid = 1'b0;
  logic [7:0] character_byte = 8'h00;
  logic       write_ready = 1'b1;
  logic       write_valid;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_byte;
  logic [4:0] top_row;

  terminal_writer dut (
    .clk            (clk),
    .reset          (reset),
    .character_ready(character_ready),
    .character_valid(character_valid),
    .character_byte (character_byte),
    .write_ready    (write_ready),
    .write_valid    (write_valid),
    .write_row      (write_row),
    .write_col      (write_col),
    .write_byte     (write_byte),
    .top_row        (top_row)
  );

  always #5 clk = ~clk;

  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int cur_line = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input int c, input logic [7:0] b);
    exp_q.push_back({5'(r), 7'(c), b});
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (write_valid === 1'b1 && write_ready === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got row %0d col %0d byte 0x%0h, expected no write",
                 write_row, write_col, write_byte);
      end else begin
        e = exp_q.pop_front();
        chk("write_cell", {write_row, write_col, write_byte}, e);
      end
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(character_ready === 1'b1 && exp_q.size() == 0) && t < 4000);
    if (t >= 4000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: got ready=%0b pending=%0d, expected ready=1 pending=0",
               name, character_ready, exp_q.size());
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (character_ready !== 1'b1 && t < 4000);
    if (t >= 4000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_send: got ready=0, expected ready=1 for byte 0x%0h", b);
    end
    @(posedge clk);
    #1 character_valid = 1'b1;
    character_byte = b;
    @(posedge clk);
    #1 character_valid = 1'b0;
  endtask

  task automatic set_wr(input logic v);
    @(posedge clk);
    #1 write_ready = v;
  endtask

  task automatic do_reset();
    int base;
    @(posedge clk);
    #1 reset = 1'b1;
    character_valid = 1'b0;
    write_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", character_ready, 0);
    chk("rst_valid", write_valid, 0);
    chk("rst_row_col", {write_row, write_col}, 0);
    chk("rst_byte", write_byte, 8'h20);
    chk("rst_top", top_row, 0);
    exp_q.delete();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 80; c++) push(r, c, 8'h20);
    base = n_writes;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", write_valid, 0);
    chk("post_rst_ready", character_ready, 0);
    wait_idle("init");
    chk("init_count", n_writes - base, 1920);
    chk("init_top", top_row, 0);
    cur_line = 0;
  endtask

  initial begin
    logic ready_bad;
    int t;
    do_reset();

    // Stalled write: outputs held, cursor does not advance until handshake.
    set_wr(1'b0);
    push(0, 0, 8'h41);
    send(8'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {write_valid, write_row, write_col, write_byte}, {1'b1, 5'd0, 7'd0, 8'h41});
      chk("stall_not_ready", character_ready, 0);
    end
    set_wr(1'b1);
    wait_idle("a");
    send(8'h0d);
    push(0, 0, 8'h42);
    send(8'h42);
    wait_idle("b");

    // Full line then wrap.
    send(8'h0d);
    for (int i = 0; i < 80; i++) begin
      push(0, i, 8'h78);
      send(8'h78);
    end
    push(1, 0, 8'h79);
    send(8'h79);
    wait_idle("wrap");
    chk("wrap_top", top_row, 0);
    cur_line = 1;

    // Backspace at col 0 and mid-line.
    send(8'h0d);
    send(8'h08);
    push(1, 0, 8'h71);
    send(8'h71);
    push(1, 1, 8'h72);
    send(8'h72);
    send(8'h08);
    push(1, 1, 8'h73);
    send(8'h73);
    wait_idle("bs");

`ifdef TERMINAL_WRITER_TAB_EN
    send(8'h0d);
    push(1, 0, 8'h61);
    send(8'h61);
    push(1, 1, 8'h62);
    send(8'h62);
    push(1, 2, 8'h63);
    send(8'h63);
    send(8'h09);
    push(1, 8, 8'h64);
    send(8'h64);
    send(8'h0d);
    for (int i = 0; i < 9; i++) send(8'h09);
    for (int i = 72; i < 77; i++) begin
      push(1, i, 8'h65);
      send(8'h65);
    end
    send(8'h09);
    push(1, 79, 8'h66);
    send(8'h66);
    wait_idle("tab");
    cur_line = 2;
`else
    send(8'h0d);
    send(8'h09);
    push(1, 0, 8'h67);
    send(8'h67);
    wait_idle("tab_off");
`endif

    // Walk to the last line, then scroll.
    while (cur_line < 23) begin
      send(8'h0a);
      cur_line++;
    end
    for (int c = 0; c < 80; c++) push(24, c, 8'h20);
    send(8'h0a);
    chk("scroll_top", top_row, 1);
    ready_bad = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (character_ready === 1'b1 && exp_q.size() != 0) ready_bad = 1'b1;
    end
    chk("clear_ready_low", ready_bad, 0);
    push(24, 0, 8'h7a);
    send(8'h7a);
    wait_idle("z");

    // Scroll until top_row wraps to 31; cursor row becomes (31+23) mod 32 = 22.
    for (int k = 2; k < 32; k++) begin
      for (int c = 0; c < 80; c++) push((k + 23) % 32, c, 8'h20);
      send(8'h0a);
      wait_idle("scroll");
    end
    chk("wrap_top31", top_row, 31);
    push(22, 0, 8'h77);
    send(8'h77);
    wait_idle("w");

    // Reset with a write pending: it must be abandoned and INIT re-run.
    set_wr(1'b0);
    send(8'h6b);
    repeat (2) @(negedge clk);
    chk("pending_valid", write_valid, 1);
    do_reset();
    push(0, 0, 8'h43);
    send(8'h43);
    wait_idle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
